// File: rtl/lc3_mem_seq.sv
// lc3_mem_seq: LC-3 style instruction/memory sequencer.
// Steps fetch, decode, load and store through a small FSM and emits
// datapath load enables decoded straight from the state register.
// Optional build macro LC3_MEM_TIMEOUT_EN adds a memory-wait watchdog
// (MEM_TIMEOUT cycles) with a sticky err flag; without it err is 0.
// state_dbg exposes the current state encoding for observation.
module lc3_mem_seq #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       op_valid,
  input  logic [1:0] op_kind,
  input  logic       mem_r,
  output logic       mem_en,
  output logic       mem_we,
  output logic       ld_mar,
  output logic       ld_mdr,
  output logic       ld_ir,
  output logic       ld_pc,
  output logic       ld_reg,
  output logic       ld_cc,
  output logic       mar_sel,
  output logic       mdr_sel,
  output logic       gate_mdr,
  output logic       instr_done,
  output logic       busy,
  output logic       err,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    F_MAR  = 4'd1,
    F_MEM  = 4'd2,
    F_IR   = 4'd3,
    DECODE = 4'd4,
    D_MAR  = 4'd5,
    D_MEM  = 4'd6,
    D_WB   = 4'd7,
    S_MAR  = 4'd8,
    S_MEM  = 4'd9
  } state_t;

  state_t state_q, state_d;
  logic   in_mem;
  logic   timeout;
  logic   instr_end;

  assign in_mem    = (state_q == F_MEM) || (state_q == D_MEM) || (state_q == S_MEM);
  assign state_dbg = state_q;

`ifdef LC3_MEM_TIMEOUT_EN
  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  // Wait counter: zero outside memory states, counts cycles without mem_r inside them.
  always_comb begin
    cnt_d   = 8'd0;
    timeout = 1'b0;
    if (in_mem && !mem_r) begin
      cnt_d   = cnt_q + 8'd1;
      timeout = (cnt_d == TMO);
    end
    err_d = err_q | timeout;
  end

  // Watchdog registers; err stays set until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // Next-state logic; instr_end marks the last cycle of an instruction.
  always_comb begin
    state_d   = state_q;
    instr_end = 1'b0;
    case (state_q)
      IDLE:   if (run && !err) state_d = F_MAR;
      F_MAR:  state_d = F_MEM;
      F_MEM:  if (timeout) state_d = IDLE;
              else if (mem_r) state_d = F_IR;
      F_IR:   state_d = DECODE;
      DECODE: if (op_valid) begin
                case (op_kind)
                  2'b00:   instr_end = 1'b1;
                  2'b01:   state_d   = D_MAR;
                  2'b10:   state_d   = S_MAR;
                  default: state_d   = IDLE;
                endcase
              end
      D_MAR:  state_d = D_MEM;
      D_MEM:  if (timeout) state_d = IDLE;
              else if (mem_r) state_d = D_WB;
      D_WB:   instr_end = 1'b1;
      S_MAR:  state_d = S_MEM;
      S_MEM:  if (timeout) state_d = IDLE;
              else if (mem_r) instr_end = 1'b1;
      default: state_d = IDLE;
    endcase
    if (instr_end) state_d = run ? F_MAR : IDLE;
  end

  // State register; reset forces IDLE, which zeroes every output at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Output decode from the state, qualified by mem_r/op_valid where needed.
  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    ld_mar     = 1'b0;
    ld_mdr     = 1'b0;
    ld_ir      = 1'b0;
    ld_pc      = 1'b0;
    ld_reg     = 1'b0;
    ld_cc      = 1'b0;
    mar_sel    = 1'b0;
    mdr_sel    = 1'b0;
    gate_mdr   = 1'b0;
    instr_done = instr_end;
    busy       = (state_q != IDLE);
    case (state_q)
      F_MAR: begin
        ld_mar = 1'b1;
        ld_pc  = 1'b1;
      end
      F_MEM, D_MEM: begin
        mem_en = 1'b1;
        ld_mdr = mem_r;
      end
      F_IR: begin
        gate_mdr = 1'b1;
        ld_ir    = 1'b1;
      end
      DECODE: begin
        if (op_valid && op_kind == 2'b00) begin
          ld_reg = 1'b1;
          ld_cc  = 1'b1;
        end
        if (op_valid && op_kind == 2'b11) instr_done = 1'b1;
      end
      D_MAR: begin
        ld_mar  = 1'b1;
        mar_sel = 1'b1;
      end
      D_WB: begin
        gate_mdr = 1'b1;
        ld_reg   = 1'b1;
        ld_cc    = 1'b1;
      end
      S_MAR: begin
        ld_mar  = 1'b1;
        mar_sel = 1'b1;
        ld_mdr  = 1'b1;
        mdr_sel = 1'b1;
      end
      S_MEM: begin
        mem_en = 1'b1;
        mem_we = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3_mem_seq.sv
// Directed bench for lc3_mem_seq. Outputs are packed as
// {mem_en, mem_we, ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc,
//  mar_sel, mdr_sel, gate_mdr, instr_done, busy, err}
// and compared against hand-written per-state constants.
module tb_lc3_mem_seq;

  localparam logic [3:0] S_IDLE = 4'd0, S_FMAR = 4'd1, S_FMEM = 4'd2, S_FIR = 4'd3,
                         S_DEC  = 4'd4, S_DMAR = 4'd5, S_DMEM = 4'd6, S_DWB = 4'd7,
                         S_SMAR = 4'd8, S_SMEM = 4'd9;

  localparam logic [13:0] O_ZERO   = 14'b00000000000000;
  localparam logic [13:0] O_FMAR   = 14'b00100100000010;
  localparam logic [13:0] O_MEM_R  = 14'b10010000000010;
  localparam logic [13:0] O_MEM_W  = 14'b10000000000010;
  localparam logic [13:0] O_FIR    = 14'b00001000001010;
  localparam logic [13:0] O_D_ALU  = 14'b00000011000110;
  localparam logic [13:0] O_BUSY   = 14'b00000000000010;
  localparam logic [13:0] O_D_HALT = 14'b00000000000110;
  localparam logic [13:0] O_DMAR   = 14'b00100000100010;
  localparam logic [13:0] O_DWB    = 14'b00000011001110;
  localparam logic [13:0] O_SMAR   = 14'b00110000110010;
  localparam logic [13:0] O_SMEM_W = 14'b11000000000010;
  localparam logic [13:0] O_SMEM_D = 14'b11000000000110;
  localparam logic [13:0] O_ERR    = 14'b00000000000001;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       run = 1'b0, op_valid = 1'b0, mem_r = 1'b0;
  logic [1:0] op_kind = 2'b00;
  logic mem_en, mem_we, ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc;
  logic mar_sel, mdr_sel, gate_mdr, instr_done, busy, err;
  logic [3:0] state_dbg;

  int checks = 0;
  int errors = 0;

  lc3_mem_seq #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .run(run), .op_valid(op_valid), .op_kind(op_kind),
    .mem_r(mem_r), .mem_en(mem_en), .mem_we(mem_we), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .ld_ir(ld_ir), .ld_pc(ld_pc), .ld_reg(ld_reg), .ld_cc(ld_cc), .mar_sel(mar_sel),
    .mdr_sel(mdr_sel), .gate_mdr(gate_mdr), .instr_done(instr_done), .busy(busy),
    .err(err), .state_dbg(state_dbg)
  );

  function automatic logic [13:0] outs();
    return {mem_en, mem_we, ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc,
            mar_sel, mdr_sel, gate_mdr, instr_done, busy, err};
  endfunction

  // checker
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver: apply inputs, check outputs/state of this cycle, advance one clock
  task automatic cyc(input string tag, input logic r, input logic ov, input logic [1:0] ok,
                     input logic mr, input logic [13:0] eo, input logic [3:0] es);
    run = r; op_valid = ov; op_kind = ok; mem_r = mr;
    #1;
    chk({tag, "_out"}, 16'(outs()), 16'(eo));
    chk({tag, "_st"}, 16'(state_dbg), 16'(es));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // reset held: IDLE, outputs zero, clock edges with run=1 do nothing
    run = 1'b1; mem_r = 1'b1; op_valid = 1'b1;
    #3;
    chk("rst_out", 16'(outs()), 16'(O_ZERO));
    chk("rst_st", 16'(state_dbg), 16'(S_IDLE));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_st", 16'(state_dbg), 16'(S_IDLE));
    run = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // leave IDLE only with run=1
    cyc("idle_run0", 0, 1, 2'b00, 1, O_ZERO, S_IDLE);
    cyc("idle_go",   1, 1, 2'b00, 1, O_ZERO, S_IDLE);

    // two back-to-back ALU instructions, zero-wait memory
    for (int i = 0; i < 2; i++) begin
      cyc("alu_fmar", 1, 1, 2'b00, 1, O_FMAR,  S_FMAR);
      cyc("alu_fmem", 1, 1, 2'b00, 1, O_MEM_R, S_FMEM);
      cyc("alu_fir",  1, 1, 2'b00, 1, O_FIR,   S_FIR);
      cyc("alu_dec",  1, 1, 2'b00, 1, O_D_ALU, S_DEC);
    end

    // LOAD: decode wait, mem_r ignored in D_MAR, three wait cycles in D_MEM
    cyc("ld_fmar",  1, 0, 2'b01, 1, O_FMAR,  S_FMAR);
    cyc("ld_fmem",  1, 0, 2'b01, 1, O_MEM_R, S_FMEM);
    cyc("ld_fir",   1, 0, 2'b01, 1, O_FIR,   S_FIR);
    cyc("ld_decw",  1, 0, 2'b00, 1, O_BUSY,  S_DEC);
    cyc("ld_dec",   1, 1, 2'b01, 1, O_BUSY,  S_DEC);
    cyc("ld_dmar",  1, 1, 2'b01, 1, O_DMAR,  S_DMAR);
    for (int i = 0; i < 3; i++)
      cyc("ld_dmemw", 1, 1, 2'b01, 0, O_MEM_W, S_DMEM);
    cyc("ld_dmem",  1, 1, 2'b01, 1, O_MEM_R, S_DMEM);
    cyc("ld_dwb",   1, 1, 2'b01, 1, O_DWB,   S_DWB);

    // STORE with one fetch wait and one store wait
    cyc("st_fmar",  1, 1, 2'b10, 0, O_FMAR,   S_FMAR);
    cyc("st_fmemw", 1, 1, 2'b10, 0, O_MEM_W,  S_FMEM);
    cyc("st_fmem",  1, 1, 2'b10, 1, O_MEM_R,  S_FMEM);
    cyc("st_fir",   1, 1, 2'b10, 0, O_FIR,    S_FIR);
    cyc("st_dec",   1, 1, 2'b10, 0, O_BUSY,   S_DEC);
    cyc("st_smar",  1, 1, 2'b10, 0, O_SMAR,   S_SMAR);
    cyc("st_smemw", 1, 1, 2'b10, 0, O_SMEM_W, S_SMEM);
    cyc("st_smem",  1, 1, 2'b10, 1, O_SMEM_D, S_SMEM);

    // run dropped during F_MEM: ALU finishes, then IDLE
    cyc("rd_fmar",  1, 1, 2'b00, 1, O_FMAR,  S_FMAR);
    cyc("rd_fmem",  0, 1, 2'b00, 1, O_MEM_R, S_FMEM);
    cyc("rd_fir",   0, 1, 2'b00, 1, O_FIR,   S_FIR);
    cyc("rd_dec",   0, 1, 2'b00, 1, O_D_ALU, S_DEC);
    cyc("rd_idle",  0, 1, 2'b00, 1, O_ZERO,  S_IDLE);

    // HALT returns to IDLE even with run=1
    cyc("h_idle",   1, 1, 2'b11, 1, O_ZERO,   S_IDLE);
    cyc("h_fmar",   1, 1, 2'b11, 1, O_FMAR,   S_FMAR);
    cyc("h_fmem",   1, 1, 2'b11, 1, O_MEM_R,  S_FMEM);
    cyc("h_fir",    1, 1, 2'b11, 1, O_FIR,    S_FIR);
    cyc("h_dec",    1, 1, 2'b11, 1, O_D_HALT, S_DEC);
    cyc("h_after",  0, 1, 2'b11, 1, O_ZERO,   S_IDLE);

`ifndef LC3_MEM_TIMEOUT_EN
    // without the watchdog a long wait just holds F_MEM
    cyc("lw_idle",  1, 1, 2'b10, 1, O_ZERO, S_IDLE);
    cyc("lw_fmar",  1, 1, 2'b10, 0, O_FMAR, S_FMAR);
    for (int i = 0; i < 20; i++)
      cyc("lw_fmemw", 1, 1, 2'b10, 0, O_MEM_W, S_FMEM);
    cyc("lw_fmem",  1, 1, 2'b10, 1, O_MEM_R, S_FMEM);
    cyc("lw_fir",   1, 1, 2'b10, 1, O_FIR,   S_FIR);
`else
    // watchdog: 15 waiting cycles in F_MEM, then IDLE with sticky err
    cyc("to_idle",  1, 1, 2'b10, 0, O_ZERO, S_IDLE);
    cyc("to_fmar",  1, 1, 2'b10, 0, O_FMAR, S_FMAR);
    for (int i = 0; i < 15; i++)
      cyc("to_fmemw", 1, 1, 2'b10, 0, O_MEM_W, S_FMEM);
    for (int i = 0; i < 3; i++)
      cyc("to_err", 1, 1, 2'b10, 1, O_ERR, S_IDLE);
    reset = 1'b0;
    #1;
    chk("to_rst_out", 16'(outs()), 16'(O_ZERO));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc("to_after", 1, 1, 2'b10, 1, O_ZERO, S_IDLE);
    cyc("to_fir0",  1, 1, 2'b10, 1, O_FMAR, S_FMAR);
    cyc("to_fmem",  1, 1, 2'b10, 1, O_MEM_R, S_FMEM);
    cyc("to_fir",   1, 1, 2'b10, 1, O_FIR,   S_FIR);
`endif
    cyc("ar_dec",   1, 1, 2'b10, 0, O_BUSY,   S_DEC);
    cyc("ar_smar",  1, 1, 2'b10, 0, O_SMAR,   S_SMAR);

    // asynchronous reset in the middle of S_MEM
    mem_r = 1'b0;
    #1;
    chk("ar_smem_out", 16'(outs()), 16'(O_SMEM_W));
    #2;
    reset = 1'b0;
    #1;
    chk("ar_now_out", 16'(outs()), 16'(O_ZERO));
    chk("ar_now_st", 16'(state_dbg), 16'(S_IDLE));
    @(posedge clk);
    #1;
    chk("ar_hold_st", 16'(state_dbg), 16'(S_IDLE));
    run = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc("ar_rel", 0, 1, 2'b00, 1, O_ZERO, S_IDLE);
    cyc("ar_go",  1, 1, 2'b00, 1, O_ZERO, S_IDLE);
    cyc("ar_fmar", 1, 1, 2'b00, 1, O_FMAR, S_FMAR);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
